mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the MEM/WB register. It consumes the registered EX results. Non-memory operations pass through with one cycle of latency. Loads and stores run as byte-serial transfers on the 8-bit memory-controller port, and the block stalls the front of the pipeline until each transfer completes. Load data is assembled little-endian and sign- or zero-extended before it goes to writeback.

---
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX/MEM inputs, the byte-serial memory-controller
// port and the MEM/WB outputs of the memory-access stage.
//   slave  : the mem_stage side (consumes in_*, mc_rdata/mc_ready; drives the rest)
//   master : the environment side (pipeline, memory controller, writeback)
// Widths: register data 32 bits, register address 5 bits.
interface mem_stage_if;
    localparam int REG_LEN      = 32;
    localparam int REG_ADDR_LEN = 5;

    // EX/MEM side
    logic                    in_valid;
    logic [REG_LEN-1:0]      in_rd_data;
    logic [REG_ADDR_LEN-1:0] in_rd_addr;
    logic                    in_rd_enable;
    logic [3:0]              in_mem_op;
    logic [REG_LEN-1:0]      in_store_data;
    logic                    stall_req;
    // memory-controller byte port
    logic                    mc_req;
    logic                    mc_we;
    logic [REG_LEN-1:0]      mc_addr;
    logic [7:0]              mc_wdata;
    logic [7:0]              mc_rdata;
    logic                    mc_ready;
    // MEM/WB side
    logic                    wb_valid;
    logic [REG_LEN-1:0]      wb_rd_data;
    logic [REG_ADDR_LEN-1:0] wb_rd_addr;
    logic                    wb_rd_enable;
    logic                    wb_misalign;

    modport slave (
        input  in_valid, in_rd_data, in_rd_addr, in_rd_enable, in_mem_op, in_store_data,
        input  mc_rdata, mc_ready,
        output stall_req, mc_req, mc_we, mc_addr, mc_wdata,
        output wb_valid, wb_rd_data, wb_rd_addr, wb_rd_enable, wb_misalign
    );

    modport master (
        output in_valid, in_rd_data, in_rd_addr, in_rd_enable, in_mem_op, in_store_data,
        output mc_rdata, mc_ready,
        input  stall_req, mc_req, mc_we, mc_addr, mc_wdata,
        input  wb_valid, wb_rd_data, wb_rd_addr, wb_rd_enable, wb_misalign
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Non-memory ops pass through in one cycle. Loads/stores run byte-serially on
// the 8-bit controller port (little-endian, addr+k for byte k) while stall_req
// holds the front of the pipeline; load data is sign/zero extended.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   rdy       global ready; low freezes all state and outputs
//   bus       mem_stage_if.slave (in_*, stall_req, mc_*, wb_*)
// Optional feature: define MEM_ALIGN_CHECK_EN to complete misaligned halfword/
// word accesses immediately with wb_misalign=1 instead of running them.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    mem_stage_if.slave  bus
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] asm_q;
    logic [4:0]  rd_addr_q;
    logic        rd_en_q;
    logic [1:0]  k;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // index of the final byte (N-1)
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    logic misalign;
`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (bus.in_mem_op)
            OP_LH, OP_LHU, OP_SH: misalign = bus.in_rd_data[0];
            OP_LW, OP_SW:         misalign = |bus.in_rd_data[1:0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    logic start_access;
    logic last_beat;
    logic [1:0]  k_nx;
    logic [31:0] word_full;
    logic [31:0] load_ext;

    assign start_access = bus.in_valid & is_mem(bus.in_mem_op) & ~misalign;
    assign last_beat    = bus.mc_ready & (k == last_idx(op_q));
    assign k_nx         = k + 2'd1;

    // Dropping stall on the completing cycle lets EX/MEM advance on that edge.
    assign bus.stall_req = (state == IDLE) ? start_access : ~last_beat;

    // assembly register with the byte arriving this cycle merged in
    always_comb begin
        word_full = asm_q;
        word_full[{k, 3'b000} +: 8] = bus.mc_rdata;
    end

    always_comb begin
        case (op_q)
            OP_LB:   load_ext = {{24{word_full[7]}}, word_full[7:0]};
            OP_LH:   load_ext = {{16{word_full[15]}}, word_full[15:0]};
            OP_LBU:  load_ext = {24'd0, word_full[7:0]};
            OP_LHU:  load_ext = {16'd0, word_full[15:0]};
            default: load_ext = word_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op_q             <= '0;
            addr_q           <= '0;
            sdata_q          <= '0;
            asm_q            <= '0;
            rd_addr_q        <= '0;
            rd_en_q          <= 1'b0;
            k                <= '0;
            bus.mc_req       <= 1'b0;
            bus.mc_we        <= 1'b0;
            bus.mc_addr      <= '0;
            bus.mc_wdata     <= '0;
            bus.wb_valid     <= 1'b0;
            bus.wb_rd_data   <= '0;
            bus.wb_rd_addr   <= '0;
            bus.wb_rd_enable <= 1'b0;
            bus.wb_misalign  <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (!bus.in_valid) begin
                        bus.wb_valid     <= 1'b0;
                        bus.wb_rd_enable <= 1'b0;
                        bus.wb_misalign  <= 1'b0;
                    end else if (start_access) begin
                        state            <= ACCESS;
                        op_q             <= bus.in_mem_op;
                        addr_q           <= bus.in_rd_data;
                        sdata_q          <= bus.in_store_data;
                        rd_addr_q        <= bus.in_rd_addr;
                        rd_en_q          <= bus.in_rd_enable;
                        asm_q            <= '0;
                        k                <= '0;
                        bus.mc_req       <= 1'b1;
                        bus.mc_we        <= is_store(bus.in_mem_op);
                        bus.mc_addr      <= bus.in_rd_data;
                        bus.mc_wdata     <= bus.in_store_data[7:0];
                        bus.wb_valid     <= 1'b0;
                        bus.wb_rd_enable <= 1'b0;
                        bus.wb_misalign  <= 1'b0;
                    end else if (misalign) begin
                        // rejected access: retire immediately, no bus traffic
                        bus.wb_valid     <= 1'b1;
                        bus.wb_rd_data   <= '0;
                        bus.wb_rd_addr   <= bus.in_rd_addr;
                        bus.wb_rd_enable <= 1'b0;
                        bus.wb_misalign  <= 1'b1;
                    end else begin
                        bus.wb_valid     <= 1'b1;
                        bus.wb_rd_data   <= bus.in_rd_data;
                        bus.wb_rd_addr   <= bus.in_rd_addr;
                        bus.wb_rd_enable <= bus.in_rd_enable;
                        bus.wb_misalign  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (bus.mc_ready) begin
                        if (k == last_idx(op_q)) begin
                            state            <= IDLE;
                            k                <= '0;
                            bus.mc_req       <= 1'b0;
                            bus.mc_we        <= 1'b0;
                            bus.wb_valid     <= 1'b1;
                            bus.wb_rd_addr   <= rd_addr_q;
                            bus.wb_misalign  <= 1'b0;
                            if (is_store(op_q)) begin
                                bus.wb_rd_enable <= 1'b0;
                                bus.wb_rd_data   <= '0;
                            end else begin
                                bus.wb_rd_enable <= rd_en_q;
                                bus.wb_rd_data   <= load_ext;
                            end
                        end else begin
                            asm_q        <= word_full;
                            k            <= k_nx;
                            bus.mc_addr  <= addr_q + {30'd0, k_nx};
                            bus.mc_wdata <= sdata_q[{k_nx, 3'b000} +: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        logic        mis;
        logic        chk_addr;
    } exp_t;

    logic [7:0]  tbmem [256];
    exp_t        sb [$];
    logic [31:0] acc_addr [$];
    logic [7:0]  acc_wdata [$];
    int n_chk  = 0;
    int n_fail = 0;
    int hold_cnt   = 0;
    int freeze_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory controller model: wait states, rdy freeze, read data from tbmem.
    always @(posedge clk) begin
        #1;
        if (bus.mc_req && hold_cnt > 0) begin
            bus.mc_ready = 1'b0;
            hold_cnt--;
        end else begin
            bus.mc_ready = bus.mc_req;
        end
        if (bus.mc_req && freeze_cnt > 0 && acc_addr.size() == 1) begin
            rdy = 1'b0;
            freeze_cnt--;
        end else begin
            rdy = 1'b1;
        end
        bus.mc_rdata = tbmem[bus.mc_addr[7:0]];
    end

    // Byte log + request stability while waiting or frozen.
    logic        p_req, p_ready, p_rdy;
    logic [31:0] p_addr;
    logic [7:0]  p_wd;
    always @(negedge clk) begin
        if (!rst && p_req && (!p_ready || !p_rdy) && bus.mc_req) begin
            chk("mc_addr_hold", bus.mc_addr, p_addr);
            chk("mc_wdata_hold", {24'd0, bus.mc_wdata}, {24'd0, p_wd});
        end
        if (!rst && bus.mc_req && bus.mc_ready && rdy) begin
            acc_addr.push_back(bus.mc_addr);
            acc_wdata.push_back(bus.mc_we ? bus.mc_wdata : 8'h00);
        end
        p_req   = bus.mc_req;
        p_ready = bus.mc_ready;
        p_rdy   = rdy;
        p_addr  = bus.mc_addr;
        p_wd    = bus.mc_wdata;
    end

    // Writeback scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_data", bus.wb_rd_data, e.data);
                chk("wb_en", {31'd0, bus.wb_rd_enable}, {31'd0, e.en});
                chk("wb_mis", {31'd0, bus.wb_misalign}, {31'd0, e.mis});
                if (e.chk_addr) chk("wb_addr", {27'd0, bus.wb_rd_addr}, {27'd0, e.addr});
            end
        end
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [4:0] rd, input logic en);
        exp_t e;
        logic [31:0] w, ai;
        int n;
        logic mis;
        e.addr = rd; e.mis = 1'b0; e.chk_addr = 1'b1; e.data = '0; e.en = 1'b0;
        mis = 1'b0;
        if (ALIGN && (op == 2 || op == 5 || op == 7) && a[0]) mis = 1'b1;
        if (ALIGN && (op == 3 || op == 8) && a[1:0] != 2'd0) mis = 1'b1;
        if (op == 0 || op > 8) begin
            e.data = a; e.en = en;
        end else if (mis) begin
            e.mis = 1'b1; e.chk_addr = 1'b0;
        end else if (op >= 6) begin
            e.chk_addr = 1'b0;
        end else begin
            w = '0;
            n = (op == 1 || op == 4) ? 1 : (op == 2 || op == 5) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
                ai = a + 32'(i);
                w[8*i +: 8] = tbmem[ai[7:0]];
            end
            if (op == 1) w = {{24{w[7]}}, w[7:0]};
            if (op == 2) w = {{16{w[15]}}, w[15:0]};
            e.data = w; e.en = en;
        end
        return e;
    endfunction

    // Present one instruction, hold it while stalled, then check wb arrives next cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic en, output int stalls);
        bit done = 0;
        sb.push_back(model(op, a, rd, en));
        acc_addr.delete();
        acc_wdata.delete();
        @(posedge clk); #2;
        bus.in_valid = 1'b1; bus.in_mem_op = op; bus.in_rd_data = a;
        bus.in_store_data = sd; bus.in_rd_addr = rd; bus.in_rd_enable = en;
        stalls = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!bus.stall_req && rdy) begin done = 1; break; end
            stalls++;
        end
        if (!done) chk("stall_timeout", 32'd1, 32'd0);
        @(posedge clk); #2;
        bus.in_valid = 1'b0; bus.in_mem_op = 4'd0;
        @(negedge clk);
        chk("wb_latency", {31'd0, bus.wb_valid}, 32'd1);
    endtask

    int st;
    initial begin
        bus.in_valid = 0; bus.in_mem_op = 0; bus.in_rd_data = 0;
        bus.in_store_data = 0; bus.in_rd_addr = 0; bus.in_rd_enable = 0;
        for (int i = 0; i < 256; i++) tbmem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("rst_mc_req", {31'd0, bus.mc_req}, 32'd0);
        chk("rst_mc_addr", bus.mc_addr, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_data", bus.wb_rd_data, 32'd0);
        chk("rst_wb_mis", {31'd0, bus.wb_misalign}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // NONE pass-through
        issue(4'd0, 32'h12345678, 32'd0, 5'd5, 1'b1, st);
        chk("none_stall", 32'(st), 32'd0);

        // LW 0x1000
        tbmem[0] = 8'h78; tbmem[1] = 8'h56; tbmem[2] = 8'h34; tbmem[3] = 8'h12;
        issue(4'd3, 32'h1000, 32'd0, 5'd7, 1'b1, st);
        chk("lw_stall", 32'(st), 32'd4);
        chk("lw_nbytes", 32'(acc_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++)
            chk("lw_addr", acc_addr[i], 32'h1000 + 32'(i));

        // sign / zero extension
        tbmem[8'h10] = 8'h80; tbmem[8'h20] = 8'h80; tbmem[8'h21] = 8'hFF;
        issue(4'd1, 32'h10, 32'd0, 5'd1, 1'b1, st);
        chk("lb_stall", 32'(st), 32'd1);
        issue(4'd4, 32'h10, 32'd0, 5'd2, 1'b1, st);
        issue(4'd2, 32'h20, 32'd0, 5'd3, 1'b1, st);
        chk("lh_stall", 32'(st), 32'd2);
        issue(4'd5, 32'h20, 32'd0, 5'd4, 1'b1, st);

        // SH with two wait states on byte 0
        hold_cnt = 2;
        issue(4'd7, 32'h2000, 32'h0000ABCD, 5'd3, 1'b1, st);
        chk("sh_stall", 32'(st), 32'd4);
        chk("sh_nbytes", 32'(acc_addr.size()), 32'd2);
        if (acc_addr.size() == 2) begin
            chk("sh_addr0", acc_addr[0], 32'h2000);
            chk("sh_wd0", {24'd0, acc_wdata[0]}, 32'hCD);
            chk("sh_addr1", acc_addr[1], 32'h2001);
            chk("sh_wd1", {24'd0, acc_wdata[1]}, 32'hAB);
        end

        // SW byte order
        issue(4'd8, 32'h50, 32'h11223344, 5'd6, 1'b1, st);
        chk("sw_nbytes", 32'(acc_addr.size()), 32'd4);
        if (acc_addr.size() == 4)
            chk("sw_wdata", {acc_wdata[3], acc_wdata[2], acc_wdata[1], acc_wdata[0]}, 32'h11223344);

        // LW with rdy dropped for 2 cycles mid-access
        tbmem[8'h40] = 8'hEF; tbmem[8'h41] = 8'hBE; tbmem[8'h42] = 8'hAD; tbmem[8'h43] = 8'hDE;
        freeze_cnt = 2;
        issue(4'd3, 32'h40, 32'd0, 5'd8, 1'b1, st);
        chk("frz_stall", 32'(st), 32'd6);
        chk("frz_nbytes", 32'(acc_addr.size()), 32'd4);

        // reset during byte 2 of an LW
        acc_addr.delete();
        @(posedge clk); #2;
        bus.in_valid = 1'b1; bus.in_mem_op = 4'd3; bus.in_rd_data = 32'h1000;
        bus.in_rd_addr = 5'd9; bus.in_rd_enable = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1; bus.in_valid = 1'b0; bus.in_mem_op = 4'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_mc_req", {31'd0, bus.mc_req}, 32'd0);
        chk("rstmid_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rstmid_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("rstmid_nbytes", 32'(acc_addr.size()), 32'd2);
        @(posedge clk); #2 rst = 1'b0;
        issue(4'd0, 32'hCAFEF00D, 32'd0, 5'd9, 1'b1, st);

        // unused op code behaves as NONE
        issue(4'd12, 32'hDEADBEEF, 32'd0, 5'd31, 1'b0, st);
        chk("op12_stall", 32'(st), 32'd0);

        // misaligned LW at 0x1002
        tbmem[4] = 8'h9A; tbmem[5] = 8'hBC;
        issue(4'd3, 32'h1002, 32'd0, 5'd10, 1'b1, st);
        chk("mis_stall", 32'(st), ALIGN ? 32'd0 : 32'd4);
        chk("mis_nbytes", 32'(acc_addr.size()), ALIGN ? 32'd0 : 32'd4);
        if (!ALIGN && acc_addr.size() == 4) chk("mis_addr3", acc_addr[3], 32'h1005);

        // address wrap at the top of the space
        tbmem[8'hFE] = 8'h01; tbmem[8'hFF] = 8'h02; tbmem[0] = 8'h03; tbmem[1] = 8'h04;
        issue(4'd3, 32'hFFFFFFFE, 32'd0, 5'd11, 1'b1, st);
        if (!ALIGN && acc_addr.size() == 4) begin
            chk("wrap_addr1", acc_addr[1], 32'hFFFFFFFF);
            chk("wrap_addr2", acc_addr[2], 32'h00000000);
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
